// File: rtl/fifo_access_checker_if.sv
// Monitored FIFO request/flag bundle. The FIFO side drives it and the
// checker only ever observes it.
interface fifo_access_checker_if;
  logic push;
  logic pop;
  logic full;
  logic empty;

  modport master (output push, output pop, output full, output empty);
  modport slave  (input  push, input  pop, input  full, input  empty);
endinterface

// File: rtl/fifo_access_checker.sv
// Passive push/pop legality checker for a FIFO: registered result pulses,
// saturating pass/fail counters and a sticky error flag.
module fifo_access_checker #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_access_checker_if.slave  mon,
  input  logic                  clr,
  output logic                  push_ok,
  output logic                  push_err,
  output logic                  pop_ok,
  output logic                  pop_err,
  output logic                  flag_conflict,
  output logic [CNT_W-1:0]      push_pass_cnt,
  output logic [CNT_W-1:0]      push_fail_cnt,
  output logic [CNT_W-1:0]      pop_pass_cnt,
  output logic [CNT_W-1:0]      pop_fail_cnt,
  output logic                  err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic push_legal;
  logic push_illegal;
  logic pop_legal;
  logic pop_illegal;
  logic conflict;

  assign push_legal   = mon.push & ~mon.full;
  assign push_illegal = mon.push &  mon.full;
  assign pop_legal    = mon.pop  & ~mon.empty;
  assign pop_illegal  = mon.pop  &  mon.empty;
  assign conflict     = mon.full &  mon.empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic            en);
    if (en && (cnt != CNT_MAX))
      return cnt + CNT_W'(1);
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_ok       <= 1'b0;
      push_err      <= 1'b0;
      pop_ok        <= 1'b0;
      pop_err       <= 1'b0;
      flag_conflict <= 1'b0;
      push_pass_cnt <= '0;
      push_fail_cnt <= '0;
      pop_pass_cnt  <= '0;
      pop_fail_cnt  <= '0;
      err_sticky    <= 1'b0;
    end else begin
      // Pulses still report the sampled cycle even when clr wipes the totals.
      push_ok       <= push_legal;
      push_err      <= push_illegal;
      pop_ok        <= pop_legal;
      pop_err       <= pop_illegal;
      flag_conflict <= conflict;
      if (clr) begin
        push_pass_cnt <= '0;
        push_fail_cnt <= '0;
        pop_pass_cnt  <= '0;
        pop_fail_cnt  <= '0;
        err_sticky    <= 1'b0;
      end else begin
        push_pass_cnt <= sat_inc(push_pass_cnt, push_legal);
        push_fail_cnt <= sat_inc(push_fail_cnt, push_illegal);
        pop_pass_cnt  <= sat_inc(pop_pass_cnt, pop_legal);
        pop_fail_cnt  <= sat_inc(pop_fail_cnt, pop_illegal);
        err_sticky    <= err_sticky | push_illegal | pop_illegal | conflict;
      end
    end
  end

endmodule

// File: tb/tb_fifo_access_checker.sv
// Directed bench for fifo_access_checker: expected results are queued as each
// stimulus cycle is driven and popped for comparison one edge later.
module tb_fifo_access_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  fifo_access_checker_if mon ();

  logic        push_ok, push_err, pop_ok, pop_err, flag_conflict, err_sticky;
  logic [15:0] push_pass_cnt, push_fail_cnt, pop_pass_cnt, pop_fail_cnt;

  logic        s_push_ok, s_push_err, s_pop_ok, s_pop_err, s_flag_conflict, s_err_sticky;
  logic [1:0]  s_push_pass_cnt, s_push_fail_cnt, s_pop_pass_cnt, s_pop_fail_cnt;

  fifo_access_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mon(mon), .clr(clr),
    .push_ok(push_ok), .push_err(push_err), .pop_ok(pop_ok), .pop_err(pop_err),
    .flag_conflict(flag_conflict),
    .push_pass_cnt(push_pass_cnt), .push_fail_cnt(push_fail_cnt),
    .pop_pass_cnt(pop_pass_cnt), .pop_fail_cnt(pop_fail_cnt),
    .err_sticky(err_sticky)
  );

  fifo_access_checker #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .mon(mon), .clr(clr),
    .push_ok(s_push_ok), .push_err(s_push_err), .pop_ok(s_pop_ok), .pop_err(s_pop_err),
    .flag_conflict(s_flag_conflict),
    .push_pass_cnt(s_push_pass_cnt), .push_fail_cnt(s_push_fail_cnt),
    .pop_pass_cnt(s_pop_pass_cnt), .pop_fail_cnt(s_pop_fail_cnt),
    .err_sticky(s_err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push_ok, push_err, pop_ok, pop_err, conflict, sticky;
    logic [15:0] ppc, pfc, opc, ofc;
    logic [1:0]  s_ppc;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_ppc, m_pfc, m_opc, m_ofc;
  logic [1:0]  m_sppc;
  logic        m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ppc = '0; m_pfc = '0; m_opc = '0; m_ofc = '0;
    m_sppc = '0; m_sticky = 1'b0;
    q.delete();
  endtask

  function automatic logic [15:0] inc16(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Drive one sample cycle, predict the registered result, compare after the edge.
  task automatic step(input string tag, input logic p, input logic f,
                      input logic o, input logic e, input logic c);
    exp_t x;
    mon.push = p; mon.full = f; mon.pop = o; mon.empty = e; clr = c;
    x.push_ok  = p & ~f;
    x.push_err = p & f;
    x.pop_ok   = o & ~e;
    x.pop_err  = o & e;
    x.conflict = f & e;
    if (c) begin
      m_ppc = '0; m_pfc = '0; m_opc = '0; m_ofc = '0; m_sppc = '0; m_sticky = 1'b0;
    end else begin
      m_ppc = inc16(m_ppc, x.push_ok);
      m_pfc = inc16(m_pfc, x.push_err);
      m_opc = inc16(m_opc, x.pop_ok);
      m_ofc = inc16(m_ofc, x.pop_err);
      if (x.push_ok && m_sppc != 2'b11) m_sppc = m_sppc + 2'd1;
      m_sticky = m_sticky | x.push_err | x.pop_err | x.conflict;
    end
    x.ppc = m_ppc; x.pfc = m_pfc; x.opc = m_opc; x.ofc = m_ofc;
    x.s_ppc = m_sppc; x.sticky = m_sticky;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({tag, ".push_ok"},  push_ok,       x.push_ok);
    chk({tag, ".push_err"}, push_err,      x.push_err);
    chk({tag, ".pop_ok"},   pop_ok,        x.pop_ok);
    chk({tag, ".pop_err"},  pop_err,       x.pop_err);
    chk({tag, ".conflict"}, flag_conflict, x.conflict);
    chk({tag, ".ppc"},      push_pass_cnt, x.ppc);
    chk({tag, ".pfc"},      push_fail_cnt, x.pfc);
    chk({tag, ".opc"},      pop_pass_cnt,  x.opc);
    chk({tag, ".ofc"},      pop_fail_cnt,  x.ofc);
    chk({tag, ".sticky"},   err_sticky,    x.sticky);
    chk({tag, ".s_ppc"},    s_push_pass_cnt, x.s_ppc);
    chk({tag, ".s_sticky"}, s_err_sticky,  x.sticky);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".outs"}, {push_ok, push_err, pop_ok, pop_err, flag_conflict, err_sticky}, 0);
    chk({tag, ".cnts"}, {push_pass_cnt, push_fail_cnt}, 0);
    chk({tag, ".cnts2"}, {pop_pass_cnt, pop_fail_cnt}, 0);
    chk({tag, ".small"}, {s_push_ok, s_push_err, s_pop_ok, s_pop_err, s_flag_conflict,
                          s_err_sticky, s_push_pass_cnt, s_push_fail_cnt,
                          s_pop_pass_cnt, s_pop_fail_cnt}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    mon.push = 1'b0; mon.pop = 1'b0; mon.full = 1'b0; mon.empty = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Build non-zero state, then pull reset asynchronously mid-cycle.
    step("pre", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("pre2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_zero("idle_end");

    // Mixed legal/illegal sequence (push, full, pop, empty).
    step("seq1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("seq2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("seq3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("seq4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("seq5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("seq_end.ppc", push_pass_cnt, 2);
    chk("seq_end.pfc", push_fail_cnt, 2);
    chk("seq_end.opc", pop_pass_cnt, 1);
    chk("seq_end.ofc", pop_fail_cnt, 2);
    chk("seq_end.sticky", err_sticky, 1);

    // clr wins over the illegal push but the pulse still appears.
    step("clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr.push_err", push_err, 1);
    chk("clr.cnts", {push_pass_cnt, push_fail_cnt, pop_pass_cnt, pop_fail_cnt}, 0);
    chk("clr.sticky", err_sticky, 0);

    // Saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) step("sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat.s_ppc", s_push_pass_cnt, 3);
    chk("sat.ppc", push_pass_cnt, 5);

    // Legal-only traffic after a clear.
    step("clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("legal", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("legal.ppc", push_pass_cnt, 10);
    chk("legal.opc", pop_pass_cnt, 10);
    chk("legal.sticky", err_sticky, 0);
    chk("legal.s_ppc", s_push_pass_cnt, 3);

    // Reset during error traffic; the in-flight sample is discarded.
    step("errs", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("errs2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk);
    #1 check_zero("rst_hold");
    model_reset();
    mon.push = 1'b0; mon.pop = 1'b0; mon.full = 1'b0; mon.empty = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_push", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post.push_ok", push_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_access_checker.md
Name: fifo_access_checker

Overview:
- Synchronous protocol checker that sits beside a FIFO and watches its push/pop requests against its full/empty flags.
- Each cycle it classifies every push and pop as legal or illegal:
  - legal push: push while not full; illegal push: push while full.
  - legal pop: pop while not empty; illegal pop: pop while empty.
- It reports per-cycle result pulses, saturating pass/fail counters and a sticky error flag for status/interrupt logic.
- Purely observational: it never drives the FIFO.

Parameters:
- CNT_W, 16, width of each pass/fail counter (minimum 1).

Ports:
- clk  input  1  sole clock; all sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  FIFO write request being monitored.
- pop  input  1  FIFO read request being monitored.
- full  input  1  FIFO full flag.
- empty  input  1  FIFO empty flag.
- clr  input  1  synchronous clear of counters and sticky flags.
- push_ok  output  1  one-cycle pulse: legal push sampled.
- push_err  output  1  one-cycle pulse: push sampled while full.
- pop_ok  output  1  one-cycle pulse: legal pop sampled.
- pop_err  output  1  one-cycle pulse: pop sampled while empty.
- flag_conflict  output  1  one-cycle pulse: full and empty both 1 sampled.
- push_pass_cnt  output  CNT_W  count of legal pushes.
- push_fail_cnt  output  CNT_W  count of illegal pushes.
- pop_pass_cnt  output  CNT_W  count of legal pops.
- pop_fail_cnt  output  CNT_W  count of illegal pops.
- err_sticky  output  1  set by any push_err, pop_err or flag_conflict event.

Behaviour:
- Reset: rst_n low asynchronously forces all outputs and counters to 0. This holds while rst_n is low and applies mid-operation; samples in flight are discarded.
- Latency: inputs sampled at rising edge N. Pulses, counter increments and err_sticky updates are visible after edge N (registered outputs, one-cycle latency). Pulses last exactly one cycle unless the condition repeats.
- Push and pop are evaluated independently. Both may be active in one cycle, giving up to two result pulses and two counter increments in the same cycle.
- push=0: no push pulse and no push counter change, regardless of full. The same applies to pop=0 versus empty.
- flag_conflict is evaluated every cycle, independent of push/pop. It also sets err_sticky.
- Counters saturate at all-ones and do not wrap.
- err_sticky stays at 1 until clr or reset.
- clr=1 at an edge:
  - zeroes all four counters and err_sticky.
  - suppresses that cycle's increments and sticky set; clr has priority.
  - result pulses for that cycle are still generated.
- Inputs with X/Z are not qualified; the bench drives known values only.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, before the next clk edge. Release, then idle (push=pop=0) for 3 cycles -> outputs remain 0.
- Apply push,full,pop,empty sequence (0,1,1,1),(1,0,1,1),(1,1,1,0),(1,0,0,1),(1,1,0,1), one per cycle, expecting in order:
  - pop_err.
  - push_ok+pop_err.
  - push_err+pop_ok.
  - push_ok.
  - push_err.
  - End: push_pass_cnt=2, push_fail_cnt=2, pop_pass_cnt=1, pop_fail_cnt=2, err_sticky=1, flag_conflict pulsed on cycles 1 and 5.
- Clear: after the above, pulse clr with push=1,full=1 -> push_err pulses, all counters=0, err_sticky=0.
- Saturation: CNT_W=2, 5 consecutive legal pushes -> push_pass_cnt reaches 3 and holds at 3.
- Legal-only traffic: push and pop with full=0, empty=0 for 10 cycles -> push_pass_cnt=10, pop_pass_cnt=10, err_sticky=0, no error pulses.
- Reset mid-stream: assert rst_n=0 during error traffic -> counters and err_sticky return to 0. No pulse on the first edge after release unless that edge's sample qualifies.
